// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RV32I controller:
// state encoding, opcodes, ALU op classes, ALU codes and mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNC
  } alu_op_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decoder: alu_op_i, funct3_i, op5_i, funct7_5_i in;
// alu_control_o out (3-bit code zero-extended to ALU_CTRL_W).
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_e               alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  op5_i,
  input  logic                  funct7_5_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    unique case (1'b1)
      (alu_op_i == ALUOP_SUB): code = ALU_SUB;
      (alu_op_i == ALUOP_FUNC): begin
        case (funct3_i)
          // only R-type (op[5]=1) with funct7[5] is a subtract
          3'b000:  code = (op5_i & funct7_5_i) ? ALU_SUB
                                               : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b100:  code = ALU_XOR;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath with memory
// ready handshake, illegal-opcode flag and retired-instruction counter.
// In: clk, reset, op, funct3, funct7_5, zero, mem_ready.
// Out: pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
//      alu_src_a, alu_src_b, imm_src, alu_control, illegal, retired.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit EN_BNE     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             br_ok;
  alu_op_e          alu_op;

  assign br_ok = (funct3 == 3'b000) ||
                 ((funct3 == 3'b001) && EN_BNE);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  state_d = S_MEMADR;
          (op == OP_R):   state_d = S_EXECR;
          (op == OP_I):   state_d = S_EXECI;
          (op == OP_BR):  state_d = br_ok ? S_BRANCH
                                          : S_ILLEGAL;
          (op == OP_JAL): state_d = S_JAL;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE:
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL:     state_d = S_ALUWB;
      S_ILLEGAL: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1)
                            : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNC;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_SUB;
        // funct3[0] selects bne over beq
        pc_write  = funct3[0] ? ~zero : zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    unique case (1'b1)
      (op == OP_SW):  imm_src = IMM_S;
      (op == OP_BR):  imm_src = IMM_B;
      (op == OP_JAL): imm_src = IMM_J;
      default:        imm_src = IMM_I;
    endcase
  end

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op_i     (alu_op),
    .funct3_i     (funct3),
    .op5_i        (op[5]),
    .funct7_5_i   (funct7_5),
    .alu_control_o(alu_control)
  );

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: two instances in lockstep,
// defaults and EN_BNE=0/CNT_W=4, checked cycle by cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [6:0] n_op = '0;
  logic [2:0] n_f3 = '0;
  logic       n_f75 = 1'b0;

  logic        a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
  logic [1:0]  a_rs, a_sa, a_sb, a_imm;
  logic [2:0]  a_ac;
  logic [15:0] a_ret;
  logic        b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
  logic [1:0]  b_rs, b_sa, b_sb, b_imm;
  logic [2:0]  b_ac;
  logic [3:0]  b_ret;

  int checks = 0;
  int errors = 0;
  int exp_r1 = 0;
  int exp_r2 = 0;

  always #5 clk = ~clk;

  multicycle_controller dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pcw), .adr_src(a_adr), .mem_write(a_mw),
    .ir_write(a_irw), .reg_write(a_rw), .result_src(a_rs),
    .alu_src_a(a_sa), .alu_src_b(a_sb), .imm_src(a_imm),
    .alu_control(a_ac), .illegal(a_ill), .retired(a_ret)
  );

  multicycle_controller #(
    .EN_BNE(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(b_pcw), .adr_src(b_adr), .mem_write(b_mw),
    .ir_write(b_irw), .reg_write(b_rw), .result_src(b_rs),
    .alu_src_a(b_sa), .alu_src_b(b_sb), .imm_src(b_imm),
    .alu_control(b_ac), .illegal(b_ill), .retired(b_ret)
  );

  logic [14:0] va, vb;
  assign va = {a_pcw, a_adr, a_mw, a_irw, a_rw,
               a_rs, a_sa, a_sb, a_ac, a_ill};
  assign vb = {b_pcw, b_adr, b_mw, b_irw, b_rw,
               b_rs, b_sa, b_sb, b_ac, b_ill};

  function automatic logic [14:0] mk(
    bit pcw, bit adr, bit mw, bit irw, bit rw,
    int rs, int sa, int sb, int ac, bit ill);
    return {pcw, adr, mw, irw, rw, 2'(rs), 2'(sa),
            2'(sb), 3'(ac), ill};
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc2(string tag, bit mr, bit z,
                      logic [14:0] e1, logic [14:0] e2);
    @(negedge clk);
    op = n_op; funct3 = n_f3; funct7_5 = n_f75;
    mem_ready = mr; zero = z;
    #1;
    check({tag, "/a"}, 32'(va), 32'(e1));
    check({tag, "/b"}, 32'(vb), 32'(e2));
  endtask

  task automatic cyc(string tag, bit mr, bit z,
                     logic [14:0] e);
    cyc2(tag, mr, z, e, e);
  endtask

  logic [14:0] V_FETCH, V_FSTALL, V_DEC, V_MA, V_MR;
  logic [14:0] V_MWB, V_MW, V_WB, V_ILL, V_JAL;

  task automatic start(string tag, logic [6:0] o,
                       logic [2:0] f3, bit f75, int imm);
    n_op = o; n_f3 = f3; n_f75 = f75;
    cyc({tag, ".F"}, 1'b1, 1'b0, V_FETCH);
    check({tag, ".imm"}, 32'(a_imm), 32'(imm));
    check({tag, ".ret_a"}, 32'(a_ret), 32'(exp_r1 & 16'hFFFF));
    check({tag, ".ret_b"}, 32'(b_ret), 32'(exp_r2 & 4'hF));
  endtask

  function automatic logic [14:0] vbr(bit p);
    return mk(p,0,0,0,0, 0,2,0,1,0);
  endfunction

  int rf3[7]  = '{0, 0, 1, 2, 4, 6, 7};
  int rf7[7]  = '{0, 1, 0, 0, 0, 0, 0};
  int rac[7]  = '{0, 1, 0, 5, 4, 3, 2};
  int if3[5]  = '{0, 2, 4, 6, 7};
  int iac[5]  = '{0, 5, 4, 3, 2};

  initial begin
    V_FETCH  = mk(1,0,0,1,0, 2,0,2,0,0);
    V_FSTALL = mk(0,0,0,0,0, 2,0,2,0,0);
    V_DEC    = mk(0,0,0,0,0, 0,1,1,0,0);
    V_MA     = mk(0,0,0,0,0, 0,2,1,0,0);
    V_MR     = mk(0,1,0,0,0, 0,0,0,0,0);
    V_MWB    = mk(0,0,0,0,1, 1,0,0,0,0);
    V_MW     = mk(0,1,1,0,0, 0,0,0,0,0);
    V_WB     = mk(0,0,0,0,1, 0,0,0,0,0);
    V_ILL    = mk(0,0,0,0,0, 0,0,0,0,1);
    V_JAL    = mk(1,0,0,0,0, 0,1,2,0,0);

    #12;
    check("rst.vec", 32'(va), 32'(V_FSTALL));
    check("rst.ret", 32'(a_ret), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    start("lw", 7'b0000011, 3'd2, 1'b0, 0);
    cyc("lw.D", 1'b1, 1'b0, V_DEC);
    cyc("lw.MA", 1'b1, 1'b0, V_MA);
    cyc("lw.MR", 1'b1, 1'b0, V_MR);
    cyc("lw.MWB", 1'b0, 1'b0, V_MWB);
    exp_r1++; exp_r2++;

    start("sw", 7'b0100011, 3'd2, 1'b0, 1);
    cyc("sw.D", 1'b0, 1'b0, V_DEC);
    cyc("sw.MA", 1'b1, 1'b0, V_MA);
    for (int i = 0; i < 3; i++)
      cyc("sw.MWs", 1'b0, 1'b0, V_MW);
    cyc("sw.MW", 1'b1, 1'b0, V_MW);
    exp_r1++; exp_r2++;

    start("beq1", 7'b1100011, 3'd0, 1'b0, 2);
    cyc("beq1.D", 1'b0, 1'b1, V_DEC);
    cyc("beq1.BR", 1'b0, 1'b1, vbr(1'b1));
    exp_r1++; exp_r2++;

    start("beq0", 7'b1100011, 3'd0, 1'b0, 2);
    cyc("beq0.D", 1'b0, 1'b0, V_DEC);
    cyc("beq0.BR", 1'b0, 1'b0, vbr(1'b0));
    exp_r1++; exp_r2++;

    start("bne", 7'b1100011, 3'd1, 1'b0, 2);
    cyc("bne.D", 1'b0, 1'b0, V_DEC);
    cyc2("bne.X", 1'b0, 1'b0, vbr(1'b1), V_ILL);
    exp_r1++;

    start("op0", 7'b0000000, 3'd0, 1'b0, 0);
    cyc("op0.D", 1'b1, 1'b0, V_DEC);
    cyc("op0.ILL", 1'b1, 1'b0, V_ILL);

    for (int i = 0; i < 7; i++) begin
      start("R", 7'b0110011, 3'(rf3[i]), rf7[i] != 0, 0);
      cyc("R.D", 1'b0, 1'b0, V_DEC);
      cyc("R.EX", 1'b0, 1'b0, mk(0,0,0,0,0, 0,2,0,rac[i],0));
      cyc("R.WB", 1'b0, 1'b0, V_WB);
      exp_r1++; exp_r2++;
    end

    for (int i = 0; i < 5; i++) begin
      start("I", 7'b0010011, 3'(if3[i]), 1'b1, 0);
      cyc("I.D", 1'b0, 1'b0, V_DEC);
      cyc("I.EX", 1'b0, 1'b0, mk(0,0,0,0,0, 0,2,1,iac[i],0));
      cyc("I.WB", 1'b0, 1'b0, V_WB);
      exp_r1++; exp_r2++;
    end

    // dut_b has now retired 16 and must read 0 here
    cyc("fstall1", 1'b0, 1'b0, V_FSTALL);
    check("wrap_b", 32'(b_ret), 32'd0);
    cyc("fstall2", 1'b0, 1'b0, V_FSTALL);

    start("jal", 7'b1101111, 3'd0, 1'b0, 3);
    cyc("jal.D", 1'b0, 1'b0, V_DEC);
    cyc("jal.J", 1'b0, 1'b0, V_JAL);
    cyc("jal.WB", 1'b0, 1'b0, V_WB);
    exp_r1++; exp_r2++;

    start("lwr", 7'b0000011, 3'd2, 1'b0, 0);
    cyc("lwr.D", 1'b0, 1'b0, V_DEC);
    cyc("lwr.MA", 1'b0, 1'b0, V_MA);
    cyc("lwr.MR", 1'b0, 1'b0, V_MR);
    #2;
    reset = 1'b1;
    #1;
    check("arst.vec", 32'(va), 32'(V_FSTALL));
    check("arst.ret_a", 32'(a_ret), 32'd0);
    check("arst.ret_b", 32'(b_ret), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_r1 = 0; exp_r2 = 0;

    start("beq2", 7'b1100011, 3'd0, 1'b0, 2);
    cyc("beq2.D", 1'b0, 1'b1, V_DEC);
    cyc("beq2.BR", 1'b0, 1'b1, vbr(1'b1));
    exp_r1++; exp_r2++;
    cyc("end.F", 1'b0, 1'b0, V_FSTALL);
    check("end.ret_a", 32'(a_ret), 32'(exp_r1));
    check("end.ret_b", 32'(b_ret), 32'(exp_r2));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
